// File: rtl/squarewave_meter_if.sv
`default_nettype none
// ============================================================================
//  Module      : squarewave_meter_if
//  Description : Signal bundle between the square-wave source/consumer side
//                and the squarewave_meter.
//                  w          - square wave under measurement (into meter)
//                  high_cnt   - high time of last complete period (CNT_W)
//                  low_cnt    - low time of last complete period (CNT_W)
//                  meas_valid - one-cycle strobe on each new measurement
//                  meas_sat   - last published measurement saturated
//                  busy       - meter is tracking a period
//                  stuck      - sticky saturation abort flag, present only
//                               when SQW_METER_STUCK_EN is defined
//                modport master : the meter side (drives results)
//                modport slave  : the source / consumer side (drives w)
//  Revision    : 1.0 - initial release
// ============================================================================
interface squarewave_meter_if #(
    parameter int CNT_W = 8
);
    logic             w;
    logic [CNT_W-1:0] high_cnt;
    logic [CNT_W-1:0] low_cnt;
    logic             meas_valid;
    logic             meas_sat;
    logic             busy;
`ifdef SQW_METER_STUCK_EN
    logic             stuck;

    modport master (
        input  w,
        output high_cnt,
        output low_cnt,
        output meas_valid,
        output meas_sat,
        output busy,
        output stuck
    );

    modport slave (
        output w,
        input  high_cnt,
        input  low_cnt,
        input  meas_valid,
        input  meas_sat,
        input  busy,
        input  stuck
    );
`else
    modport master (
        input  w,
        output high_cnt,
        output low_cnt,
        output meas_valid,
        output meas_sat,
        output busy
    );

    modport slave (
        output w,
        input  high_cnt,
        input  low_cnt,
        input  meas_valid,
        input  meas_sat,
        input  busy
    );
`endif
endinterface
`default_nettype wire

// File: rtl/squarewave_meter.sv
`default_nettype none
// ============================================================================
//  Module      : squarewave_meter
//  Description : Measures high and low time (in clk cycles) of every complete
//                period of a possibly asynchronous square wave and publishes
//                each result with a one-cycle valid strobe.
//  Ports       : clk   - system clock, rising edge
//                reset - synchronous, active-high reset
//                bus   - squarewave_meter_if.master
//                          in : w
//                          out: high_cnt, low_cnt, meas_valid, meas_sat, busy
//                               (+ stuck when SQW_METER_STUCK_EN is defined)
//  Parameters  : CNT_W       - counter/result width (>= 2)
//                SYNC_STAGES - input synchroniser depth (>= 2)
//  Options     : SQW_METER_STUCK_EN - when defined, a saturating phase aborts
//                the period, raises sticky 'stuck' and returns to IDLE.
//  Revision    : 1.0 - initial release
// ============================================================================
module squarewave_meter #(
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  wire logic           clk,
    input  wire logic           reset,
    squarewave_meter_if.master  bus
);

    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_MAX_M1 = {{(CNT_W-1){1'b1}}, 1'b0};
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MEAS_HIGH = 2'd1,
        MEAS_LOW  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Input synchroniser and edge detection
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   w_d;
    logic [SYNC_STAGES:0]   settle_q;
    logic                   w_s;
    logic                   settled;
    logic                   rise;
    logic                   fall;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q   <= '0;
            w_d      <= 1'b0;
            settle_q <= '0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], bus.w};
            w_d      <= w_s;
            settle_q <= {settle_q[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign w_s = sync_q[SYNC_STAGES-1];

    // The synchroniser and delayed copy restart from 0 after reset, so a
    // wave that is already high would look like a fresh rising edge while
    // the pipeline refills. Edges are only trusted once every stage plus
    // the delayed copy holds a genuine post-reset sample of w.
    assign settled = settle_q[SYNC_STAGES];
    assign rise    = settled &  w_s & ~w_d;
    assign fall    = settled & ~w_s &  w_d;

    // ------------------------------------------------------------------
    // Measurement FSM with registered outputs
    // ------------------------------------------------------------------
    state_t           state;
    logic [CNT_W-1:0] hcnt;
    logic [CNT_W-1:0] lcnt;
    logic             hsat;
    logic             lsat;
    logic [CNT_W-1:0] high_cnt_q;
    logic [CNT_W-1:0] low_cnt_q;
    logic             meas_valid_q;
    logic             meas_sat_q;
    logic             busy_q;
`ifdef SQW_METER_STUCK_EN
    logic             stuck_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            hcnt         <= '0;
            lcnt         <= '0;
            hsat         <= 1'b0;
            lsat         <= 1'b0;
            high_cnt_q   <= '0;
            low_cnt_q    <= '0;
            meas_valid_q <= 1'b0;
            meas_sat_q   <= 1'b0;
            busy_q       <= 1'b0;
`ifdef SQW_METER_STUCK_EN
            stuck_q      <= 1'b0;
`endif
        end else begin
            meas_valid_q <= 1'b0;

            case (state)
                IDLE: begin
                    // The first rising edge only arms the meter; there is
                    // no preceding low phase to report yet.
                    if (rise) begin
                        hcnt   <= CNT_ONE;
                        hsat   <= 1'b0;
                        state  <= MEAS_HIGH;
                        busy_q <= 1'b1;
                    end
                end

                MEAS_HIGH: begin
                    if (fall) begin
                        lcnt  <= CNT_ONE;
                        lsat  <= 1'b0;
                        state <= MEAS_LOW;
                    end else if (w_s) begin
`ifdef SQW_METER_STUCK_EN
                        // The increment that would land on the ceiling
                        // aborts the period instead of publishing it.
                        if (hcnt >= CNT_MAX_M1) begin
                            stuck_q <= 1'b1;
                            state   <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            hcnt <= hcnt + CNT_ONE;
                        end
`else
                        if (hcnt != CNT_MAX) begin
                            hcnt <= hcnt + CNT_ONE;
                        end
                        if (hcnt >= CNT_MAX_M1) begin
                            hsat <= 1'b1;
                        end
`endif
                    end
                end

                MEAS_LOW: begin
                    if (rise) begin
                        // Publish the finished period and start the next
                        // high phase in the same cycle.
                        high_cnt_q   <= hcnt;
                        low_cnt_q    <= lcnt;
                        meas_sat_q   <= hsat | lsat;
                        meas_valid_q <= 1'b1;
                        hcnt         <= CNT_ONE;
                        hsat         <= 1'b0;
                        state        <= MEAS_HIGH;
                    end else if (!w_s) begin
`ifdef SQW_METER_STUCK_EN
                        if (lcnt >= CNT_MAX_M1) begin
                            stuck_q <= 1'b1;
                            state   <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            lcnt <= lcnt + CNT_ONE;
                        end
`else
                        if (lcnt != CNT_MAX) begin
                            lcnt <= lcnt + CNT_ONE;
                        end
                        if (lcnt >= CNT_MAX_M1) begin
                            lsat <= 1'b1;
                        end
`endif
                    end
                end

                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.high_cnt   = high_cnt_q;
    assign bus.low_cnt    = low_cnt_q;
    assign bus.meas_valid = meas_valid_q;
    assign bus.meas_sat   = meas_sat_q;
    assign bus.busy       = busy_q;
`ifdef SQW_METER_STUCK_EN
    assign bus.stuck      = stuck_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_squarewave_meter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_squarewave_meter
//  Description : Self-checking bench for squarewave_meter. Two instances
//                (CNT_W=8 and CNT_W=4) watch the same clk-aligned wave.
//                A phase-level reference model predicts, for each complete
//                period, the strobe cycle and the clamped high/low times.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_squarewave_meter;

    localparam int SYNC = 2;
    localparam int W_A  = 8;
    localparam int W_B  = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic w_drv = 1'b0;
    int   cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    squarewave_meter_if #(.CNT_W(W_A)) bus_a ();
    squarewave_meter_if #(.CNT_W(W_B)) bus_b ();

    assign bus_a.w = w_drv;
    assign bus_b.w = w_drv;

    squarewave_meter #(.CNT_W(W_A), .SYNC_STAGES(SYNC)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a.master)
    );

    squarewave_meter #(.CNT_W(W_B), .SYNC_STAGES(SYNC)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b.master)
    );

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input int obs, input int expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, obs, expv);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: works on whole phases of the driven wave
    // ------------------------------------------------------------------
    typedef struct {
        int inst;
        int cyc;
        int h;
        int l;
        int sat;
    } exp_t;

    exp_t q[$];
    int   maxv [2] = '{255, 15};
    int   exp_h[2] = '{0, 0};
    int   exp_l[2] = '{0, 0};
    int   exp_s[2] = '{0, 0};
    bit   armed    = 1'b0;
    bit   have_low = 1'b0;
    bit   prev_lvl = 1'b0;
    int   busy_from = 32'h7fff_ffff;
    int   cur_len  = 0;
    int   h_len    = 0;

    function automatic int clampv(input int v, input int m);
        return (v > m) ? m : v;
    endfunction

    // Called at a negedge; w changes there and is first sampled at the
    // following posedge (edge k = cyc+1). The strobe is seen after edge
    // k+SYNC.
    task automatic phase(input bit lvl, input int len);
        if (lvl && !prev_lvl) begin
            if (armed && have_low) begin
                for (int i = 0; i < 2; i++) begin
                    exp_t e;
                    e.inst = i;
                    e.cyc  = cyc + 1 + SYNC;
                    e.h    = clampv(h_len, maxv[i]);
                    e.l    = clampv(cur_len, maxv[i]);
                    e.sat  = (h_len >= maxv[i] || cur_len >= maxv[i]) ? 1 : 0;
                    q.push_back(e);
                end
            end
            if (!armed) begin
                armed     = 1'b1;
                busy_from = cyc + 1 + SYNC;
            end
            have_low = 1'b0;
            cur_len  = len;
        end else if (!lvl && prev_lvl) begin
            h_len    = cur_len;
            have_low = armed;
            cur_len  = len;
        end else begin
            cur_len += len;
        end
        w_drv    = lvl;
        prev_lvl = lvl;
        repeat (len) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rst.a.meas_valid", int'(bus_a.meas_valid), 0);
        chk("rst.a.high_cnt",   int'(bus_a.high_cnt),   0);
        chk("rst.a.low_cnt",    int'(bus_a.low_cnt),    0);
        chk("rst.a.meas_sat",   int'(bus_a.meas_sat),   0);
        chk("rst.a.busy",       int'(bus_a.busy),       0);
        chk("rst.b.meas_valid", int'(bus_b.meas_valid), 0);
        chk("rst.b.high_cnt",   int'(bus_b.high_cnt),   0);
        chk("rst.b.low_cnt",    int'(bus_b.low_cnt),    0);
        chk("rst.b.busy",       int'(bus_b.busy),       0);
        @(negedge clk);
        armed     = 1'b0;
        have_low  = 1'b0;
        busy_from = 32'h7fff_ffff;
        q.delete();
        for (int i = 0; i < 2; i++) begin
            exp_h[i] = 0;
            exp_l[i] = 0;
            exp_s[i] = 0;
        end
        reset = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Per-cycle monitor, sampled 1 time unit after each rising edge
    // ------------------------------------------------------------------
    always @(posedge clk) begin
        int    hit;
        int    v, h, l, s, b;
        string nm;
        #1;
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                nm = (i == 0) ? "a" : "b";
                v  = (i == 0) ? int'(bus_a.meas_valid) : int'(bus_b.meas_valid);
                h  = (i == 0) ? int'(bus_a.high_cnt)   : int'(bus_b.high_cnt);
                l  = (i == 0) ? int'(bus_a.low_cnt)    : int'(bus_b.low_cnt);
                s  = (i == 0) ? int'(bus_a.meas_sat)   : int'(bus_b.meas_sat);
                b  = (i == 0) ? int'(bus_a.busy)       : int'(bus_b.busy);
                hit = -1;
                for (int j = 0; j < q.size(); j++) begin
                    if (q[j].inst == i && q[j].cyc == cyc) hit = j;
                end
                if (hit >= 0) begin
                    chk({nm, ".meas_valid"}, v, 1);
                    exp_h[i] = q[hit].h;
                    exp_l[i] = q[hit].l;
                    exp_s[i] = q[hit].sat;
                    q.delete(hit);
                end else begin
                    chk({nm, ".meas_valid"}, v, 0);
                end
                chk({nm, ".high_cnt"}, h, exp_h[i]);
                chk({nm, ".low_cnt"},  l, exp_l[i]);
                chk({nm, ".meas_sat"}, s, exp_s[i]);
                chk({nm, ".busy"},     b, (armed && cyc >= busy_from) ? 1 : 0);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        @(negedge clk);
        do_reset();
        phase(1'b0, 5);

        // Regular 10 high / 15 low wave; first rise only arms.
        for (int n = 0; n < 4; n++) begin
            phase(1'b1, 10);
            phase(1'b0, 15);
        end

        // Minimum pulses, one cycle each.
        for (int n = 0; n < 6; n++) begin
            phase(1'b1, 1);
            phase(1'b0, 1);
        end

        // Saturating high phase for the narrow instance.
        for (int n = 0; n < 3; n++) begin
            phase(1'b1, 20);
            phase(1'b0, 3);
        end

        // Random periods, occasionally long enough to saturate both widths.
        for (int n = 0; n < 40; n++) begin
            int hl, ll;
            hl = (($urandom % 8) == 0) ? int'($urandom_range(250, 300)) : int'($urandom_range(1, 20));
            ll = (($urandom % 8) == 0) ? int'($urandom_range(250, 300)) : int'($urandom_range(1, 20));
            phase(1'b1, hl);
            phase(1'b0, ll);
        end

        // Reset during a high phase; w stays high through release.
        phase(1'b1, 6);
        do_reset();
        phase(1'b1, 5);
        phase(1'b0, 6);
        phase(1'b1, 7);
        phase(1'b0, 8);
        phase(1'b1, 4);
        phase(1'b0, 5);

        // Wave already high at reset release must not count as an edge.
        phase(1'b1, 4);
        do_reset();
        phase(1'b1, 10);
        phase(1'b0, 5);
        phase(1'b1, 6);
        phase(1'b0, 7);
        phase(1'b1, 3);
        phase(1'b0, 10);

        chk("pending_strobes", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/squarewave_meter.md
Name: squarewave_meter

Overview:
- Downstream consumer of the on-chip square-wave generator output `w`.
- Synchronises `w`, detects its edges, and measures the high time and low time of each complete period in clk cycles.
- Publishes each completed measurement with a one-cycle valid strobe, for a display or self-check stage.
- Also flags measurements that overflowed the counter width.

Parameters:
- CNT_W, 8, width of the high/low cycle counters and result outputs; legal range ≥ 2.
- SYNC_STAGES, 2, number of flip-flops in the input synchroniser; legal range ≥ 2.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- w  input  1  square wave under measurement; may be asynchronous to clk.
- high_cnt  output  CNT_W  clk cycles the last complete period spent high.
- low_cnt  output  CNT_W  clk cycles the last complete period spent low.
- meas_valid  output  1  one-cycle strobe: high_cnt/low_cnt/meas_sat just updated.
- meas_sat  output  1  the last published measurement saturated in either phase.
- busy  output  1  high while in MEAS_HIGH or MEAS_LOW.

Behaviour:
- Interface: one clock `clk`; reset `reset` is synchronous and active-high.
- Reset values: high_cnt=0, low_cnt=0, meas_valid=0, meas_sat=0, busy=0, state=IDLE. Synchroniser flops, delayed copy and internal counters are all 0.
- Synchroniser:
  - w passes through SYNC_STAGES flops to give w_s; w_d is w_s delayed one cycle.
  - rise = w_s & ~w_d; fall = ~w_s & w_d.
- State IDLE:
  - Ignores level; a high level at reset release is not a rising edge.
  - On rise: hcnt<=1, hsat<=0, go MEAS_HIGH. Nothing is published.
- State MEAS_HIGH:
  - While w_s=1: hcnt<=hcnt+1, saturating at 2^CNT_W−1. Reaching saturation sets hsat.
  - On fall: lcnt<=1, lsat<=0, go MEAS_LOW.
- State MEAS_LOW:
  - While w_s=0: lcnt<=lcnt+1, saturating at 2^CNT_W−1. Reaching saturation sets lsat.
  - On rise, in a single cycle:
    - high_cnt<=hcnt; low_cnt<=lcnt.
    - meas_sat<=hsat|lsat; meas_valid<=1.
    - hcnt<=1, hsat<=0; stay in a new MEAS_HIGH.
- meas_valid:
  - Registered; high for exactly one cycle per completed period, else 0.
  - Result outputs hold their value between strobes.
- Latency:
  - Let k be the first clk edge sampling w=1 after a low phase.
  - meas_valid is high in the cycle after edge k+SYNC_STAGES.
  - Counts are exact for phases ≥ 1 cycle after synchronisation.
- First period rule: after reset, the first rising edge only arms the meter. The first strobe comes on the second rising edge.
- Saturation:
  - Counters never wrap.
  - A saturated phase reports 2^CNT_W−1 with meas_sat=1.
  - The meter continues tracking edges normally.
- Reset mid-operation: clears everything to reset values and returns to IDLE. No strobe for the interrupted period.
- Simultaneous reset and rise: reset wins.
- busy: 1 in MEAS_HIGH/MEAS_LOW, 0 in IDLE.

Optional Feature:
- Macro: SQW_METER_STUCK_EN.
- Defined:
  - Adds output `stuck` (1 bit, reset 0).
  - If hcnt or lcnt reaches saturation, the meter sets stuck=1 (sticky until reset) and returns to IDLE immediately.
  - The in-flight period is discarded: no meas_valid, results unchanged.
- Not defined:
  - No stuck port.
  - Saturation behaves as described above: the meter keeps measuring and reports meas_sat.

Test Plan:
- Reset, then w = 10 high / 15 low repeated, CNT_W=8 → no strobe on the first rise. Every subsequent rise gives meas_valid for one cycle with high_cnt=10, low_cnt=15, meas_sat=0.
- Strobe timing: w rises, first sampled at edge k → meas_valid high only in the cycle after edge k+2 (SYNC_STAGES=2).
- Minimum pulse: w = 1 high / 1 low, clk-aligned → high_cnt=1, low_cnt=1 on every strobe.
- Saturation: CNT_W=4, w = 20 high / 3 low → high_cnt=15, low_cnt=3, meas_sat=1. With SQW_METER_STUCK_EN instead: stuck=1, no meas_valid, state IDLE.
- Reset mid-period: assert reset for 1 cycle during a high phase → all outputs 0, busy=0. The next strobe needs two further rising edges.
- w held high through reset release → stays in IDLE, busy=0, no strobe until w falls and rises, then completes one full period.
